// File: rtl/concot_pkg.sv
// Shared types and constants for the concot word-to-bit unpacker.
package concot_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int CONCOT_WIDTH_DEFAULT = 26;

endpackage

// File: rtl/concot_bitcnt.sv
// Bit index counter for the unpacker: loads to zero, steps per transferred bit,
// flags the final index and clears itself after that bit leaves.
module concot_bitcnt #(
  parameter int LAST_IDX = 25,
  parameter int IW       = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  output logic [IW-1:0] idx,
  output logic          last
);

  assign last = (idx == IW'(LAST_IDX));

  // Clearing on the final step keeps the index parked at zero between words
  always_ff @(posedge clk) begin
    if (rst || load) begin
      idx <= '0;
    end else if (en) begin
      idx <= last ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/concot_unpack.sv
// Parallel word to serial bit unpacker with valid/ready on both sides.
// Optional trailing even-parity bit when CONCOT_UNPACK_PARITY_EN is defined.
module concot_unpack
  import concot_pkg::*;
#(
  parameter int WIDTH = CONCOT_WIDTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [0:WIDTH-1]           inp,
  input  logic                       inp_valid,
  output logic                       inp_ready,
  output logic                       otp,
  output logic                       otp_valid,
  input  logic                       otp_ready,
  output logic [$clog2(WIDTH+1)-1:0] otp_idx,
  output logic                       otp_last
);

  localparam int IW = $clog2(WIDTH+1);
`ifdef CONCOT_UNPACK_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif

  state_t        state, state_nxt;
  logic [0:NB-1] sreg_p0;
  logic          take, give, cnt_last;

  assign take = (state == IDLE) && inp_valid;
  assign give = (state == SHIFT) && otp_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (inp_valid)            state_nxt = SHIFT;
      SHIFT:   if (otp_ready && cnt_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: captured word; the current bit always sits at position 0
  always_ff @(posedge clk) begin
    if (take) begin
`ifdef CONCOT_UNPACK_PARITY_EN
      sreg_p0 <= {inp, ^inp};
`else
      sreg_p0 <= inp;
`endif
    end else if (give) begin
      sreg_p0 <= {sreg_p0[1:NB-1], 1'b0};
    end
  end

  concot_bitcnt #(
    .LAST_IDX (NB - 1),
    .IW       (IW)
  ) u_bitcnt (
    .clk  (clk),
    .rst  (rst),
    .load (take),
    .en   (give),
    .idx  (otp_idx),
    .last (cnt_last)
  );

  // Data register is not reset, so outputs are qualified by state instead
  assign inp_ready = (state == IDLE);
  assign otp_valid = (state == SHIFT);
  assign otp       = otp_valid & sreg_p0[0];
  assign otp_last  = otp_valid & cnt_last;

endmodule

// File: tb/tb_concot_unpack.sv
// Scoreboard bench for concot_unpack; parity expectations follow CONCOT_UNPACK_PARITY_EN.
module tb_concot_unpack;

  localparam int W  = 26;
  localparam int IW = $clog2(W+1);
`ifdef CONCOT_UNPACK_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  localparam int PERIOD = NB + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [0:W-1]  inp;
  logic          inp_valid;
  logic          inp_ready;
  logic          otp;
  logic          otp_valid;
  logic          otp_ready;
  logic [IW-1:0] otp_idx;
  logic          otp_last;

  concot_unpack #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .inp       (inp),
    .inp_valid (inp_valid),
    .inp_ready (inp_ready),
    .otp       (otp),
    .otp_valid (otp_valid),
    .otp_ready (otp_ready),
    .otp_idx   (otp_idx),
    .otp_last  (otp_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          b;
    logic [IW-1:0] idx;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int   acc_t[$];
  int   acc_idle[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   idle_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void push_word(input logic [0:W-1] w);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.b    = w[i];
      e.idx  = IW'(i);
      e.last = (i == NB - 1);
      sb.push_back(e);
    end
`ifdef CONCOT_UNPACK_PARITY_EN
    e.b    = ^w;
    e.idx  = IW'(W);
    e.last = 1'b1;
    sb.push_back(e);
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  logic          hold_v = 1'b0;
  logic          hold_b;
  logic [IW-1:0] hold_i;
  logic          hold_l;

  // Observe on the falling edge: what is seen here is what the next rising edge acts on
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_vld", 32'(otp_valid), 32'(1));
        check("hold_otp", 32'(otp), 32'(hold_b));
        check("hold_idx", 32'(otp_idx), 32'(hold_i));
        check("hold_last", 32'(otp_last), 32'(hold_l));
      end
      if (!otp_valid) begin
        idle_cnt++;
        check("idle_last", 32'(otp_last), 32'(0));
      end
      if (inp_valid && inp_ready) begin
        push_word(inp);
        acc_t.push_back(cyc);
        acc_idle.push_back(idle_cnt);
      end
      if (otp_valid && otp_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_bit", 32'(1), 32'(0));
        end else begin
          e = sb.pop_front();
          check("bit_otp", 32'(otp), 32'(e.b));
          check("bit_idx", 32'(otp_idx), 32'(e.idx));
          check("bit_last", 32'(otp_last), 32'(e.last));
        end
      end
      hold_v = otp_valid && !otp_ready;
      hold_b = otp;
      hold_i = otp_idx;
      hold_l = otp_last;
    end
  end

  task automatic send(input logic [0:W-1] w);
    int n = 0;
    inp       = w;
    inp_valid = 1'b1;
    while (!inp_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_timeout", 32'(n < 200), 32'(1));
    @(posedge clk); #1;
    inp_valid = 1'b0;
  endtask

  task automatic wait_idx(input int idx);
    int n = 0;
    while (!(otp_valid && otp_idx == IW'(idx)) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_idx_timeout", 32'(n < 200), 32'(1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !inp_ready) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", 32'(n < 500), 32'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_otp_valid"}, 32'(otp_valid), 32'(0));
    check({tag, "_inp_ready"}, 32'(inp_ready), 32'(1));
    check({tag, "_otp"}, 32'(otp), 32'(0));
    check({tag, "_otp_idx"}, 32'(otp_idx), 32'(0));
    check({tag, "_otp_last"}, 32'(otp_last), 32'(0));
  endtask

  initial begin
    int n;
    int base;
    rst       = 1'b1;
    inp       = '0;
    inp_valid = 1'b0;
    otp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;

    // Single word, consumer always ready
    send(26'h2000001);
    n = 0;
    while (!inp_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_period", 32'(n + 1), 32'(PERIOD));
    wait_idle();

    // Consumer stalls at index 5 for four cycles
    send(26'h3FFFFFF);
    wait_idx(5);
    otp_ready = 1'b0;
    repeat (4) begin
      check("stall_otp", 32'(otp), 32'(1));
      check("stall_idx", 32'(otp_idx), 32'(5));
      @(posedge clk); #1;
    end
    otp_ready = 1'b1;
    wait_idle();

    // Second word offered while the first is in flight; inp churns meanwhile
    base = acc_t.size();
    send(26'h1555555);
    inp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inp = W'($urandom());
      check("busy_ready", 32'(inp_ready), 32'(0));
      @(posedge clk); #1;
    end
    inp = 26'h0ABCDEF;
    n = 0;
    while (acc_t.size() < base + 2 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("second_accept_timeout", 32'(n < 200), 32'(1));
    @(posedge clk); #1;
    inp_valid = 1'b0;
    if (acc_t.size() >= base + 2)
      check("second_accept_gap", 32'(acc_t[base+1] - acc_t[base]), 32'(PERIOD));
    wait_idle();

    // Reset in the middle of a word
    send(26'h2AAAAAA);
    wait_idx(10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("midrst");
    send(26'h0000F0F);
    wait_idle();

`ifdef CONCOT_UNPACK_PARITY_EN
    // Parity bit values for odd and even population
    send(26'h0000007);
    wait_idx(W);
    check("par_odd_otp", 32'(otp), 32'(1));
    check("par_odd_last", 32'(otp_last), 32'(1));
    wait_idle();
    send(26'h0000003);
    wait_idx(W);
    check("par_even_otp", 32'(otp), 32'(0));
    check("par_even_last", 32'(otp_last), 32'(1));
    wait_idle();
`endif

    // Back-to-back words with inp_valid held high
    base      = acc_t.size();
    inp       = W'($urandom());
    inp_valid = 1'b1;
    n = 0;
    while (acc_t.size() < base + 3 && n < 400) begin
      @(posedge clk); #1;
      if (acc_t.size() > base) inp = W'($urandom());
      n++;
    end
    check("b2b_timeout", 32'(n < 400), 32'(1));
    @(posedge clk); #1;
    inp_valid = 1'b0;
    if (acc_t.size() >= base + 3) begin
      for (int i = 1; i < 3; i++) begin
        check("b2b_period", 32'(acc_t[base+i] - acc_t[base+i-1]), 32'(PERIOD));
        check("b2b_bubbles", 32'(acc_idle[base+i] - acc_idle[base+i-1]), 32'(1));
      end
    end
    wait_idle();
    check("sb_drained", 32'(sb.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
